// File: rtl/la_ioin_ctrl_pkg.sv
// Shared types for the input-pad controller: FSM state encoding.
package la_ioin_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        PULL  = 2'd1,
        WAIT  = 2'd2,
        APPLY = 2'd3
    } state_t;

endpackage

// File: rtl/la_ioin_debounce.sv
// One pad bit: two-flop synchronizer followed by a saturating-threshold debouncer.
module la_ioin_debounce #(
    parameter int unsigned DBW = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_z,
    input  logic i_ie,
    output logic o_din,
    output logic o_chg
);

    localparam logic [DBW-1:0] CNT_MAX = '1;

    logic           r_s1;
    logic           r_s2;
    logic           r_din;
    logic           r_chg;
    logic [DBW-1:0] r_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_din <= 1'b0;
            r_chg <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_z;
            r_s2  <= r_s1;
            r_chg <= 1'b0;
            if (!i_ie || (r_s2 == r_din)) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Mismatch held for 2^DBW edges: commit and restart, never wrap.
                r_din <= r_s2;
                r_chg <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DBW'(1);
            end
        end
    end

    assign o_din = r_din;
    assign o_chg = r_chg;

endmodule

// File: rtl/la_ioin_ctrl.sv
// Input-pad controller: serialised ie/pe/ps reconfiguration with a pull-settle wait,
// plus per-pad synchronized and debounced input data.
module la_ioin_ctrl
    import la_ioin_ctrl_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned SETTLE = 16,
    parameter int unsigned DBW    = 4,
    localparam int unsigned SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [SW-1:0] cfg_sel,
    input  logic          cfg_ie,
    input  logic          cfg_pe,
    input  logic          cfg_ps,
    output logic [N-1:0]  ie,
    output logic [N-1:0]  pe,
    output logic [N-1:0]  ps,
    input  logic [N-1:0]  z,
    output logic [N-1:0]  din,
    output logic [N-1:0]  chg,
    output logic          busy
);

    localparam int unsigned CNT_W = 8;

    state_t             r_state;
    state_t             w_state_d;
    logic               w_accept;
    logic               w_sel_ok;
    logic [N-1:0]       w_mask;
    logic [SW-1:0]      r_sel;
    logic               r_ie_req;
    logic               r_pe_req;
    logic               r_ps_req;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_ie;
    logic [N-1:0]       r_pe;
    logic [N-1:0]       r_ps;

    assign w_sel_ok = (32'(cfg_sel) < N);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_sel == SW'(i)) w_mask[i] = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Out-of-range selects are consumed but leave the FSM idle.
                if (cfg_valid) begin
                    w_accept = 1'b1;
                    if (w_sel_ok) w_state_d = PULL;
                end
            end
            PULL:    w_state_d = WAIT;
            WAIT:    if (r_cnt == '0) w_state_d = APPLY;
            APPLY:   w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_ie_req <= 1'b0;
            r_pe_req <= 1'b0;
            r_ps_req <= 1'b0;
            r_cnt    <= '0;
            r_ie     <= '0;
            r_pe     <= '0;
            r_ps     <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_sel    <= cfg_sel;
                r_ie_req <= cfg_ie;
                r_pe_req <= cfg_pe;
                r_ps_req <= cfg_ps;
            end
            case (r_state)
                PULL: begin
                    r_ie  <= r_ie & ~w_mask;
                    r_pe  <= (r_pe & ~w_mask) | (w_mask & {N{r_pe_req}});
                    r_ps  <= (r_ps & ~w_mask) | (w_mask & {N{r_ps_req}});
                    r_cnt <= CNT_W'(SETTLE - 1);
                end
                WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                APPLY: begin
                    r_ie <= (r_ie & ~w_mask) | (w_mask & {N{r_ie_req}});
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_pad
        la_ioin_debounce #(
            .DBW (DBW)
        ) u_debounce (
            .clk    (clk),
            .nreset (nreset),
            .i_z    (z[g]),
            .i_ie   (r_ie[g]),
            .o_din  (din[g]),
            .o_chg  (chg[g])
        );
    end

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign ie        = r_ie;
    assign pe        = r_pe;
    assign ps        = r_ps;

endmodule

// File: doc/la_ioin_ctrl.md
LA_IOIN_CTRL -- requirements
Module: la_ioin_ctrl

Interface
REQ-001 Parameter N, default 8: number of input pads controlled (1..64).
REQ-002 Parameter SETTLE, default 16: pull-settle wait, in clk cycles (1..255).
REQ-003 Parameter DBW, default 4: debounce counter width; threshold is 2^DBW-1.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 nreset  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration request valid.
REQ-007 cfg_ready  output  1  controller can accept a request.
REQ-008 cfg_sel  input  max(1,$clog2(N))  target pad index.
REQ-009 cfg_ie, cfg_pe, cfg_ps  input  1 each  requested input-enable, pull-enable and pull-select (1=up) values.
REQ-010 ie, pe, ps  output  N each  per-pad controls driven to the pad cells.
REQ-011 z  input  N  raw pad-to-core data, asynchronous to clk.
REQ-012 din  output  N  synchronized, debounced pad data.
REQ-013 chg  output  N  one-cycle pulse when the corresponding din bit changes.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states: IDLE, PULL, WAIT, APPLY; cfg_ready SHALL equal (state==IDLE).
REQ-016 Handshake: request accepted on the cycle with cfg_valid && cfg_ready; cfg_* sampled only then; cfg_valid may be held with changing data without effect while not ready.
REQ-017 IDLE -> PULL on acceptance with cfg_sel < N; with cfg_sel >= N the request is accepted, no output changes, and the FSM remains in IDLE.
REQ-018 PULL (1 cycle): ie[sel] <= 0, pe[sel] <= cfg_pe, ps[sel] <= cfg_ps, wait counter loaded with SETTLE-1; -> WAIT.
REQ-019 WAIT: counter decrements each cycle; at counter==0 -> APPLY (PULL to APPLY entry = SETTLE+1 cycles).
REQ-020 APPLY (1 cycle): ie[sel] <= cfg_ie (registered value); -> IDLE; next request acceptable the cycle after APPLY.
REQ-021 Pads other than sel SHALL never change ie/pe/ps during a sequence.
REQ-022 Each z bit SHALL pass through a two-flop synchronizer before any use.
REQ-023 Per pad: if ie==0, debounce counter held at 0 and din/chg held (chg=0).
REQ-024 Per pad with ie==1: sync!=din increments counter; sync==din clears counter; when counter==2^DBW-1 and sync!=din, next edge sets din<=sync, chg<=1, counter<=0.
REQ-025 Latency: stable z change to din update = 2 + 2^DBW cycles; chg asserted in the same cycle din changes, for exactly one cycle.
REQ-026 A glitch shorter than 2^DBW synchronized cycles SHALL not change din.
REQ-027 Counter SHALL not wrap; a mismatch run longer than threshold yields exactly one update.

Reset
REQ-028 On nreset low: state IDLE, cfg_ready=1, busy=0, ie/pe/ps/din/chg all 0, synchronizers and counters 0.
REQ-029 Reset asserted mid-sequence SHALL abort it; no partial pad update survives reset.
REQ-030 Reset deassertion SHALL be accepted as-is; the block does not synchronize nreset internally.

Structure
REQ-031 Package la_ioin_ctrl_pkg holds the FSM state enum (IDLE, PULL, WAIT, APPLY) and state width constant.
REQ-032 Sub-module la_ioin_debounce (synchronizer + counter + din/chg, one bit, DBW parameter), instantiated N times.

Verification
REQ-033 Reset then cfg sel=3, ie=1, pe=1, ps=1, SETTLE=16 -> pe[3]=ps[3]=1 one cycle after accept, ie[3]=1 exactly 18 cycles after accept, cfg_ready low throughout.
REQ-034 cfg_valid held during busy with different sel -> ignored until IDLE, then accepted once; other pads unchanged.
REQ-035 cfg_sel=N (out of range) -> accepted, busy stays 0, all outputs unchanged.
REQ-036 ie[0]=1, z[0] 0->1 held, DBW=4 -> din[0]=1 and chg[0]=1 for one cycle 18 cycles later.
REQ-037 z[1] pulse of 10 cycles with ie[1]=1 -> din[1] stays 0, chg[1] never asserts; same stimulus with ie[1]=0 and 40-cycle pulse -> no change.
REQ-038 nreset asserted during WAIT -> all outputs 0 immediately; after release new request completes normally.
